// File: rtl/uart_pkg.sv
// Shared UART types: parity modes, TX/RX state encodings, parity helper.
// Imported by the UART core and its receive engine.
package uart_pkg;

  localparam int MAX_BITS = 16;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  // Zero-extended data leaves the XOR unchanged, so one width serves all.
  function automatic logic parity_bit(
    input logic [MAX_BITS-1:0] data,
    input logic [1:0]          mode
  );
    return (mode == PAR_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_rx_engine.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM and
// the host-visible valid/error/overrun flags.
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rx_clr,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [1:0]    PMODE     = PARITY[1:0];

  logic                 rx_meta;
  logic                 rx_sync;
  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_pend;
  logic                 frm_pend;
  logic                 done;
  logic                 tick;

  assign tick = (cnt == BIT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= RX_IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      par_pend <= 1'b0;
      frm_pend <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        RX_IDLE: begin
          if (!rx_sync) begin
            state    <= RX_START;
            cnt      <= '0;
            par_pend <= 1'b0;
            frm_pend <= 1'b0;
          end
        end
        RX_START: begin
          cnt <= cnt + 1'b1;
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_sync ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick) begin
            shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
            if (idx == DATA_LAST) begin
              idx   <= '0;
              state <= (PMODE != PAR_NONE) ? RX_PARITY : RX_STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        RX_PARITY: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick) begin
            par_pend <= rx_sync ^ parity_bit(MAX_BITS'(shreg), PMODE);
            idx      <= '0;
            state    <= RX_STOP;
          end
        end
        RX_STOP: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick) begin
            if (!rx_sync) frm_pend <= 1'b1;
            if (idx == STOP_LAST) begin
              done  <= 1'b1;
              idx   <= '0;
              // A low stop level may be a break; wait for idle first.
              state <= (frm_pend || !rx_sync) ? RX_WAIT_IDLE : RX_IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        RX_WAIT_IDLE: begin
          if (rx_sync) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else if (done) begin
      if (!rx_valid || rx_clr) begin
        rx_valid      <= 1'b1;
        rx_data       <= shreg;
        rx_parity_err <= par_pend;
        rx_frame_err  <= frm_pend;
        if (rx_clr) rx_overrun <= 1'b0;
      end else begin
        rx_overrun <= 1'b1;
      end
    end else if (rx_clr) begin
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: inline TX FSM with valid/ready
// handshake plus the uart_rx_engine receiver.
module uart_core_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  input  logic                 rx,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_clr,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  if (CLKS_PER_BIT < 4) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
    $error("DATA_BITS must be within 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [1:0]    PMODE     = PARITY[1:0];

  tx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par;
  logic                 tick;

  assign tick    = (cnt == BIT_LAST);
  assign tx_busy = ~tx_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= TX_IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      unique case (state)
        TX_IDLE: begin
          if (tx_valid) begin
            shreg    <= tx_data;
            par      <= parity_bit(MAX_BITS'(tx_data), PMODE);
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            cnt      <= '0;
            state    <= TX_START;
          end
        end
        TX_START: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick) begin
            tx    <= shreg[0];
            idx   <= '0;
            state <= TX_DATA;
          end
        end
        TX_DATA: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick) begin
            if (idx == DATA_LAST) begin
              idx <= '0;
              if (PMODE != PAR_NONE) begin
                tx    <= par;
                state <= TX_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= TX_STOP;
              end
            end else begin
              idx   <= idx + 1'b1;
              shreg <= shreg >> 1;
              tx    <= shreg[1];
            end
          end
        end
        TX_PARITY: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick) begin
            tx    <= 1'b1;
            idx   <= '0;
            state <= TX_STOP;
          end
        end
        TX_STOP: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick) begin
            if (idx == STOP_LAST) begin
              tx_ready <= 1'b1;
              state    <= TX_IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  uart_rx_engine #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_BITS   (DATA_BITS),
    .PARITY      (PARITY),
    .STOP_BITS   (STOP_BITS)
  ) u_rx (
    .clock        (clock),
    .reset        (reset),
    .rx           (rx),
    .rx_clr       (rx_clr),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param: 16 clk/bit, 8 data, even parity,
// 1 stop; TX waveform, loopback, error, overrun, glitch and reset cases.
module tb_uart_core_param;

  logic       clock = 1'b0;
  logic       reset;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx;
  logic       tx_busy;
  logic       rx;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_clr;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_overrun;

  logic loop;
  logic rx_drv;

  int n_cmp = 0;
  int n_err = 0;

  assign rx = loop ? tx : rx_drv;

  always #5 clock = ~clock;

  uart_core_param #(
    .CLKS_PER_BIT(16),
    .DATA_BITS   (8),
    .PARITY      (1),
    .STOP_BITS   (1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .rx           (rx),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_clr       (rx_clr),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send_tx(input logic [7:0] d);
    int n = 0;
    @(negedge clock);
    while (!tx_ready && n < 400) begin
      @(negedge clock);
      n++;
    end
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic p,
                         input logic s);
    rx_drv = 1'b0;
    repeat (16) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (16) @(negedge clock);
    end
    rx_drv = p;
    repeat (16) @(negedge clock);
    rx_drv = s;
    repeat (16) @(negedge clock);
  endtask

  task automatic wait_rx();
    int n = 0;
    while (!rx_valid && n < 400) begin
      @(negedge clock);
      n++;
    end
    check("rx_wait", 32'(rx_valid), 1);
  endtask

  task automatic pulse_clr();
    @(negedge clock);
    rx_clr = 1'b1;
    @(negedge clock);
    rx_clr = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic v,
                             input logic pe, input logic fe,
                             input logic ov);
    check({tag, "_valid"}, 32'(rx_valid), 32'(v));
    check({tag, "_perr"}, 32'(rx_parity_err), 32'(pe));
    check({tag, "_ferr"}, 32'(rx_frame_err), 32'(fe));
    check({tag, "_ovr"}, 32'(rx_overrun), 32'(ov));
  endtask

  initial begin
    logic [10:0] a5_bits;
    int cyc;
    int low;

    // start, 1,0,1,0,0,1,0,1, parity 0, stop (index 0 sent first)
    a5_bits  = 11'b1_0_10100101_0;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rx_clr   = 1'b0;
    loop     = 1'b0;
    rx_drv   = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_tx", 32'(tx), 1);
    check("rst_ready", 32'(tx_ready), 1);
    check("rst_busy", 32'(tx_busy), 0);
    check("rst_data", 32'(rx_data), 0);
    check_flags("rst", 0, 0, 0, 0);

    send_tx(8'hA5);
    check("a5_busy", 32'(tx_busy), 1);
    cyc = 0;
    low = 0;
    while (!tx_ready && cyc < 400) begin
      low++;
      if (cyc % 16 == 8)
        check($sformatf("a5_bit%0d", cyc / 16), 32'(tx),
              32'(a5_bits[cyc / 16]));
      @(negedge clock);
      cyc++;
    end
    check("a5_ready_low", 32'(low), 176);
    check("a5_idle_tx", 32'(tx), 1);

    loop = 1'b1;
    send_tx(8'h3C);
    wait_rx();
    check("lb1_data", 32'(rx_data), 32'h3C);
    check_flags("lb1", 1, 0, 0, 0);
    pulse_clr();
    send_tx(8'hFF);
    wait_rx();
    check("lb2_data", 32'(rx_data), 32'hFF);
    check_flags("lb2", 1, 0, 0, 0);
    pulse_clr();
    check_flags("lb_clr", 0, 0, 0, 0);
    repeat (200) @(negedge clock);
    loop = 1'b0;
    repeat (20) @(negedge clock);

    send_rx(8'h01, 1'b0, 1'b1);
    wait_rx();
    check("perr_data", 32'(rx_data), 32'h01);
    check_flags("perr", 1, 1, 0, 0);
    pulse_clr();
    check_flags("perr_clr", 0, 0, 0, 0);
    check("perr_keep", 32'(rx_data), 32'h01);

    send_rx(8'h55, 1'b0, 1'b0);
    wait_rx();
    check("ferr_data", 32'(rx_data), 32'h55);
    check_flags("ferr", 1, 0, 1, 0);
    pulse_clr();
    repeat (500) @(negedge clock);
    check("brk_valid", 32'(rx_valid), 0);
    rx_drv = 1'b1;
    repeat (40) @(negedge clock);

    send_rx(8'h11, 1'b0, 1'b1);
    send_rx(8'h22, 1'b0, 1'b1);
    repeat (4) @(negedge clock);
    check("ovr_data", 32'(rx_data), 32'h11);
    check_flags("ovr", 1, 0, 0, 1);
    pulse_clr();
    check_flags("ovr_clr", 0, 0, 0, 0);
    repeat (20) @(negedge clock);

    // rx_clr lands in the completion cycle of the second frame
    send_rx(8'h11, 1'b0, 1'b1);
    fork
      send_rx(8'h22, 1'b0, 1'b1);
      begin
        repeat (171) @(negedge clock);
        rx_clr = 1'b1;
        @(negedge clock);
        rx_clr = 1'b0;
      end
    join
    repeat (4) @(negedge clock);
    check("coin_data", 32'(rx_data), 32'h22);
    check_flags("coin", 1, 0, 0, 0);
    pulse_clr();

    rx_drv = 1'b0;
    repeat (5) @(negedge clock);
    rx_drv = 1'b1;
    repeat (200) @(negedge clock);
    check_flags("glitch", 0, 0, 0, 0);

    send_tx(8'h5A);
    repeat (20) @(negedge clock);
    check("mid_tx", 32'(tx), 0);
    #2 reset = 1'b1;
    #1;
    check("rst_async_tx", 32'(tx), 1);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_ready", 32'(tx_ready), 1);
    check("post_rst_busy", 32'(tx_busy), 0);
    repeat (50) @(negedge clock);
    check("post_rst_tx", 32'(tx), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
